mem_access_multi: RTL and testbench

Memory access unit for the multicycle RISC-V core, directly downstream of the multicycle control FSM. It turns the FSM's single-cycle MemRead/MemWrite/IouD strobes into a req/ack transaction on a word-wide memory port. It performs byte/halfword lane steering and extension, and latches the results into the instruction register (IR) and memory data register (MDR). While a transaction is in flight it asserts a stall so the control FSM holds its state.

---
 rtl/mem_access_multi_if.sv | 28 ++
 rtl/mem_access_multi.sv | 182 ++++++++++++++++++
 tb/tb_mem_access_multi.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_multi_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// mem_access_multi_if: word-wide req/ack memory port of the access unit.
// Revision: 1.0
// ============================================================================
interface mem_access_multi_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] oMemAddr;
  logic [31:0]       oMemWData;
  logic [3:0]        oMemBE;
  logic              oMemReq;
  logic              oMemWE;
  logic [31:0]       iMemRData;
  logic              iMemAck;

  modport master (
    output oMemAddr, oMemWData, oMemBE, oMemReq, oMemWE,
    input  iMemRData, iMemAck
  );

  modport slave (
    input  oMemAddr, oMemWData, oMemBE, oMemReq, oMemWE,
    output iMemRData, iMemAck
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// mem_access_multi: turns control-FSM MemRead/MemWrite strobes into a req/ack
// memory transaction with lane steering, filling IR/MDR. Optional macro:
// MISALIGN_TRAP_EN (misaligned accesses complete without a bus request).
// Revision: 1.0
// ============================================================================
module mem_access_multi #(
  parameter int ADDR_W = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iMemRead,
  input  logic              iMemWrite,
  input  logic              iIouD,
  input  logic [ADDR_W-1:0] iPC,
  input  logic [ADDR_W-1:0] iALUOut,
  input  logic [31:0]       iWriteData,
  input  logic [2:0]        iFunct3,
  output logic [31:0]       oIR,
  output logic [31:0]       oMDR,
  output logic              oBusy,
  output logic              oDone,
  output logic              oMisaligned,
  mem_access_multi_if.master mem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:2] addr_hi_q, addr_hi_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              is_data_q, is_data_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       mdr_q, mdr_d;
`ifdef MISALIGN_TRAP_EN
  logic              mis_q, mis_d;
`endif

  logic              start;
  logic [ADDR_W-1:0] addr_in;
  logic              in_byte, in_half, mis_in;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       ld_ext;

  always_comb begin
    start   = iMemRead | iMemWrite;
    addr_in = iIouD ? iALUOut : iPC;
    // lbu/lhu encodings are only sized accesses on the load side
    in_byte = iIouD & ((iFunct3 == 3'b000) | (~iMemWrite & (iFunct3 == 3'b100)));
    in_half = iIouD & ((iFunct3 == 3'b001) | (~iMemWrite & (iFunct3 == 3'b101)));
`ifdef MISALIGN_TRAP_EN
    mis_in  = in_byte ? 1'b0 : (in_half ? addr_in[0] : (addr_in[1:0] != 2'b00));
`else
    mis_in  = 1'b0;
`endif

    case (addr_lo_q)
      2'd0:    rd_byte = mem.iMemRData[7:0];
      2'd1:    rd_byte = mem.iMemRData[15:8];
      2'd2:    rd_byte = mem.iMemRData[23:16];
      default: rd_byte = mem.iMemRData[31:24];
    endcase
    rd_half = addr_lo_q[1] ? mem.iMemRData[31:16] : mem.iMemRData[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  ld_ext = {24'd0, rd_byte};
      3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  ld_ext = {16'd0, rd_half};
      default: ld_ext = mem.iMemRData;
    endcase

    state_d   = state_q;
    addr_hi_d = addr_hi_q;
    addr_lo_d = addr_lo_q;
    funct3_d  = funct3_q;
    is_data_d = is_data_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    ir_d      = ir_q;
    mdr_d     = mdr_q;
`ifdef MISALIGN_TRAP_EN
    mis_d     = mis_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_hi_d = addr_in[ADDR_W-1:2];
          addr_lo_d = addr_in[1:0];
          funct3_d  = iFunct3;
          is_data_d = iIouD;
          we_d      = iMemWrite;
          if (in_byte) begin
            be_d    = 4'b0001 << addr_in[1:0];
            wdata_d = {4{iWriteData[7:0]}};
          end else if (in_half) begin
            be_d    = 4'b0011 << {addr_in[1], 1'b0};
            wdata_d = {2{iWriteData[15:0]}};
          end else begin
            be_d    = 4'b1111;
            wdata_d = iWriteData;
          end
`ifdef MISALIGN_TRAP_EN
          mis_d     = mis_in;
`endif
          state_d   = mis_in ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (mem.iMemAck) begin
          if (!we_q) begin
            if (is_data_q) mdr_d = ld_ext;
            else           ir_d  = mem.iMemRData;
          end
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= S_IDLE;
      addr_hi_q <= '0;
      addr_lo_q <= 2'd0;
      funct3_q  <= 3'd0;
      is_data_q <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
      ir_q      <= 32'd0;
      mdr_q     <= 32'd0;
`ifdef MISALIGN_TRAP_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_hi_q <= addr_hi_d;
      addr_lo_q <= addr_lo_d;
      funct3_q  <= funct3_d;
      is_data_q <= is_data_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
`ifdef MISALIGN_TRAP_EN
      mis_q     <= mis_d;
`endif
    end
  end

  assign oIR           = ir_q;
  assign oMDR          = mdr_q;
  assign oDone         = (state_q == S_DONE);
  assign oBusy         = (state_q == S_REQ) | ((state_q == S_IDLE) & start);
`ifdef MISALIGN_TRAP_EN
  assign oMisaligned   = (state_q == S_DONE) & mis_q;
`else
  assign oMisaligned   = 1'b0;
`endif
  assign mem.oMemReq   = (state_q == S_REQ);
  assign mem.oMemWE    = (state_q == S_REQ) & we_q;
  assign mem.oMemAddr  = {addr_hi_q, 2'b00};
  assign mem.oMemBE    = be_q;
  assign mem.oMemWData = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_mem_access_multi: randomized transactions against a transaction-level
// model of the access unit, plus literal checks for the documented scenarios.
// Revision: 1.0
// ============================================================================
module tb_mem_access_multi;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        iRST = 1'b1;
  logic        iMemRead = 1'b0, iMemWrite = 1'b0, iIouD = 1'b0;
  logic [31:0] iPC = '0, iALUOut = '0, iWriteData = '0;
  logic [2:0]  iFunct3 = '0;
  logic [31:0] oIR, oMDR;
  logic        oBusy, oDone, oMisaligned;

  mem_access_multi_if #(.ADDR_W(32)) mem_if ();

  mem_access_multi #(.ADDR_W(32)) dut (
    .iCLK(clk), .iRST(iRST), .iMemRead(iMemRead), .iMemWrite(iMemWrite),
    .iIouD(iIouD), .iPC(iPC), .iALUOut(iALUOut), .iWriteData(iWriteData),
    .iFunct3(iFunct3), .oIR(oIR), .oMDR(oMDR), .oBusy(oBusy), .oDone(oDone),
    .oMisaligned(oMisaligned), .mem(mem_if.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // expected per-cycle outputs, maintained by the transaction driver
  logic        m_busy = 0, m_done = 0, m_mis = 0, m_req = 0, m_we = 0;
  logic [31:0] m_ir = 0, m_mdr = 0, m_addr = 0, m_wd = 0;
  logic [3:0]  m_be = 0;
  logic        seen_req, seen_we;
  logic [31:0] seen_addr, seen_wd;
  logic [3:0]  seen_be;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> (8 * a);
    b  = sh[7:0];
    h  = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'd0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] f_store_be(input logic [2:0] f3, input logic [1:0] a);
    if (f3 == 3'd0) return 4'b0001 << a;
    if (f3 == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] f_store_wd(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return {4{d[7:0]}};
    if (f3 == 3'd1) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic bit f_mis(input bit fetch, input bit we, input logic [2:0] f3, input logic [1:0] a);
    if (fetch) return a != 2'd0;
    if (f3 == 3'd0 || (!we && f3 == 3'd4)) return 1'b0;
    if (f3 == 3'd1 || (!we && f3 == 3'd5)) return a[0];
    return a != 2'd0;
  endfunction

  always @(negedge clk) begin
    check("busy", oBusy, m_busy);
    check("done", oDone, m_done);
    check("misaligned", oMisaligned, m_mis);
    check("req", mem_if.oMemReq, m_req);
    check("ir", oIR, m_ir);
    check("mdr", oMDR, m_mdr);
    if (m_req) begin
      check("addr", mem_if.oMemAddr, m_addr);
      check("we", mem_if.oMemWE, m_we);
      if (m_we) begin
        check("be", mem_if.oMemBE, m_be);
        check("wdata", mem_if.oMemWData, m_wd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one complete access; called at posedge+1 with the DUT idle
  task automatic txn(input bit rd, input bit wr, input bit io, input logic [31:0] addr,
                     input logic [2:0] f3, input logic [31:0] wd, input logic [31:0] rword,
                     input int dly, input bit poke);
    bit fetch, trap;
    fetch = !io;
    trap  = TRAP && f_mis(fetch, wr, f3, addr[1:0]);
    seen_req = 1'b0;
    iMemRead = rd; iMemWrite = wr; iIouD = io; iFunct3 = f3; iWriteData = wd;
    iPC     = io ? $urandom : addr;
    iALUOut = io ? addr : $urandom;
    m_busy = 1; m_req = 0; m_done = 0;
    tick();
    iMemRead = 0; iMemWrite = 0;
    if (trap) begin
      m_busy = 0; m_done = 1; m_mis = 1;
      seen_req = mem_if.oMemReq;
    end else begin
      m_req = 1; m_we = wr; m_addr = {addr[31:2], 2'b00};
      m_be = f_store_be(f3, addr[1:0]); m_wd = f_store_wd(f3, wd);
      repeat (dly) tick();
      seen_req = mem_if.oMemReq; seen_we = mem_if.oMemWE; seen_addr = mem_if.oMemAddr;
      seen_be = mem_if.oMemBE; seen_wd = mem_if.oMemWData;
      mem_if.iMemAck = 1; mem_if.iMemRData = rword;
      tick();
      mem_if.iMemAck = 0;
      m_req = 0; m_busy = 0; m_done = 1;
      if (!wr) begin
        if (fetch) m_ir = rword;
        else       m_mdr = f_load(f3, addr[1:0], rword);
      end
    end
    if (poke) begin
      iMemRead = 1; mem_if.iMemAck = 1; mem_if.iMemRData = $urandom;
    end
    tick();
    iMemRead = 0; mem_if.iMemAck = 0;
    m_done = 0; m_mis = 0;
  endtask

  initial begin
    mem_if.iMemAck = 0;
    mem_if.iMemRData = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ir", oIR, 32'h0);
    check("rst_mdr", oMDR, 32'h0);
    check("rst_req", mem_if.oMemReq, 32'h0);
    check("rst_addr", mem_if.oMemAddr, 32'h0);
    check("rst_be", mem_if.oMemBE, 32'h0);
    check("rst_wdata", mem_if.oMemWData, 32'h0);
    iRST = 0;
    tick();

    txn(1, 0, 0, 32'h100, 3'd2, 32'h0, 32'h00A00093, 0, 0);
    check("fetch_ir", oIR, 32'h00A00093);
    check("fetch_addr", seen_addr, 32'h100);
    txn(1, 0, 1, 32'h203, 3'd0, 32'h0, 32'h80FF7F01, 0, 0);
    check("lb_mdr", oMDR, 32'hFFFFFF80);
    txn(1, 0, 1, 32'h203, 3'd4, 32'h0, 32'h80FF7F01, 1, 0);
    check("lbu_mdr", oMDR, 32'h00000080);
    txn(0, 1, 1, 32'h402, 3'd1, 32'h1234ABCD, 32'h55555555, 0, 0);
    check("sh_wdata", seen_wd, 32'hABCDABCD);
    check("sh_be", seen_be, 32'hC);
    check("sh_we", seen_we, 32'h1);
    check("sh_mdr_kept", oMDR, 32'h00000080);
    check("sh_ir_kept", oIR, 32'h00A00093);
    txn(1, 0, 1, 32'h500, 3'd2, 32'h0, 32'h11223344, 4, 0);
    check("lw_slow_mdr", oMDR, 32'h11223344);
    for (int g = 0; g < 3; g++) begin
      mem_if.iMemAck = 1; mem_if.iMemRData = 32'hFFFFFFFF;
      tick();
    end
    mem_if.iMemAck = 0;
    check("stray_mdr", oMDR, 32'h11223344);
    txn(1, 0, 1, 32'h301, 3'd2, 32'h0, 32'hDEADBEEF, 0, 0);
    if (TRAP) begin
      check("trap_noreq", seen_req, 32'h0);
      check("trap_mdr", oMDR, 32'h11223344);
    end else begin
      check("lw301_addr", seen_addr, 32'h300);
      check("lw301_mdr", oMDR, 32'hDEADBEEF);
    end

    // reset while a fetch is waiting for its ack
    iMemRead = 1; iIouD = 0; iPC = 32'h80; m_busy = 1;
    tick();
    iMemRead = 0; m_req = 1; m_we = 0; m_addr = 32'h80;
    tick();
    #2;
    iRST = 1;
    m_req = 0; m_busy = 0; m_ir = 0; m_mdr = 0;
    #1;
    check("rst_mid_req", mem_if.oMemReq, 32'h0);
    check("rst_mid_ir", oIR, 32'h0);
    check("rst_mid_mdr", oMDR, 32'h0);
    tick();
    iRST = 0;
    mem_if.iMemAck = 1; mem_if.iMemRData = 32'hCAFEF00D;
    tick();
    mem_if.iMemAck = 0;
    tick();

    for (int t = 0; t < 300; t++) begin
      bit io, rd, wr;
      logic [31:0] a;
      io = ($urandom_range(0, 3) != 0);
      if (!io) begin
        rd = 1; wr = 0;
      end else begin
        wr = $urandom_range(0, 1) != 0;
        rd = wr ? ($urandom_range(0, 1) != 0) : 1'b1;
      end
      a = 32'($urandom_range(0, 4095));
      if (!io && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      txn(rd, wr, io, a, 3'($urandom_range(0, 7)), $urandom, $urandom,
          $urandom_range(0, 4), $urandom_range(0, 3) == 0);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        mem_if.iMemAck = $urandom_range(0, 1) != 0; mem_if.iMemRData = $urandom;
        tick();
      end
      mem_if.iMemAck = 0;
    end

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
